// File: rtl/digital_clock_core_if.sv
// Time-set handshake bundle for digital_clock_core.
//
// The requester (master) presents set_valid for one cycle together with the
// HH/MM/SS fields; the clock core (slave) answers one cycle later with a
// set_ack pulse and a set_err flag that says whether the fields were rejected.
//
// Signals:
//   set_valid  master -> slave  one-cycle load request
//   set_hh     master -> slave  hour to load (0..23 accepted)
//   set_mm     master -> slave  minute to load (0..59 accepted)
//   set_ss     master -> slave  second to load (0..59 accepted)
//   set_ack    slave -> master  one-cycle pulse, cycle after set_valid
//   set_err    slave -> master  1 = last request rejected, valid with set_ack

interface digital_clock_core_if;
  logic       set_valid;
  logic [4:0] set_hh;
  logic [5:0] set_mm;
  logic [5:0] set_ss;
  logic       set_ack;
  logic       set_err;

  modport master (
    output set_valid,
    output set_hh,
    output set_mm,
    output set_ss,
    input  set_ack,
    input  set_err
  );

  modport slave (
    input  set_valid,
    input  set_hh,
    input  set_mm,
    input  set_ss,
    output set_ack,
    output set_err
  );
endinterface

// File: rtl/digital_clock_core.sv
// HH:MM:SS timekeeper running directly from the board oscillator.
//
// A prescaler counting 0..CLK_HZ-1 produces a one-cycle 1 Hz enable; no clock
// is derived. Time can be loaded through a validated set handshake, advanced
// or frozen with run_en, and presented to a 7-segment driver as either HH:MM
// or MM:SS, alternating every DISP_SEC seconds.
//
// Parameters:
//   CLK_HZ    clkin frequency in Hz (prescaler period in cycles), >= 2
//   DISP_SEC  seconds each display pair is shown before toggling, >= 1
//
// Ports:
//   clkin      system clock, rising edge
//   reset_n    asynchronous active-low reset
//   run_en     1 = prescaler and time counters advance, 0 = hold
//   set_if     time-set handshake (slave side)
//   tick_1hz   one-cycle pulse, high in the cycle the seconds advance
//   hours      current hour 0..23
//   minutes    current minute 0..59
//   seconds    current second 0..59
//   disp_sel   0 = HH:MM shown, 1 = MM:SS shown
//   disp_hi    hours (zero-extended) or minutes
//   disp_lo    minutes or seconds
//
// Optional alarm, enabled by defining DIGITAL_CLOCK_ALARM_EN:
//   alarm_hh   alarm hour
//   alarm_mm   alarm minute
//   alarm_arm  1 = alarm may fire
//   alarm_clr  synchronous clear of alarm_out
//   alarm_out  sticky alarm flag

module digital_clock_core #(
  parameter int unsigned CLK_HZ   = 50000000,
  parameter int unsigned DISP_SEC = 10
) (
  input  logic       clkin,
  input  logic       reset_n,
  input  logic       run_en,
  digital_clock_core_if.slave set_if,
  output logic       tick_1hz,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       disp_sel,
  output logic [5:0] disp_hi,
  output logic [5:0] disp_lo
`ifdef DIGITAL_CLOCK_ALARM_EN
  ,
  input  logic [4:0] alarm_hh,
  input  logic [5:0] alarm_mm,
  input  logic       alarm_arm,
  input  logic       alarm_clr,
  output logic       alarm_out
`endif
);

  localparam int unsigned PresW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned DispW = (DISP_SEC > 1) ? $clog2(DISP_SEC) : 1;
  localparam logic [PresW-1:0] PresMax = PresW'(CLK_HZ - 1);
  localparam logic [DispW-1:0] DispMax = DispW'(DISP_SEC - 1);

  logic [PresW-1:0] presc_q, presc_d;
  logic [4:0]       hh_q, hh_d;
  logic [5:0]       mm_q, mm_d;
  logic [5:0]       ss_q, ss_d;
  logic [DispW-1:0] disp_cnt_q, disp_cnt_d;
  logic             disp_sel_q, disp_sel_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;

  logic             wrap;
  logic             set_ok;
  logic             set_load;

  assign wrap     = run_en && (presc_q == PresMax);
  assign set_ok   = (set_if.set_hh <= 5'd23) && (set_if.set_mm <= 6'd59) &&
                    (set_if.set_ss <= 6'd59);
  assign set_load = set_if.set_valid && set_ok;

  always_comb begin
    presc_d    = presc_q;
    hh_d       = hh_q;
    mm_d       = mm_q;
    ss_d       = ss_q;
    disp_cnt_d = disp_cnt_q;
    disp_sel_d = disp_sel_q;
    tick_d     = wrap;
    ack_d      = set_if.set_valid;
    err_d      = err_q;

    if (run_en) begin
      presc_d = wrap ? '0 : presc_q + 1'b1;
    end

    if (wrap) begin
      if (ss_q == 6'd59) begin
        ss_d = '0;
        if (mm_q == 6'd59) begin
          mm_d = '0;
          hh_d = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
        end else begin
          mm_d = mm_q + 6'd1;
        end
      end else begin
        ss_d = ss_q + 6'd1;
      end

      // Display pacing follows tick_1hz, including a tick overridden by a set.
      if (disp_cnt_q == DispMax) begin
        disp_cnt_d = '0;
        disp_sel_d = ~disp_sel_q;
      end else begin
        disp_cnt_d = disp_cnt_q + 1'b1;
      end
    end

    // A valid set overrides any coincident advance and restarts the second.
    if (set_load) begin
      presc_d = '0;
      hh_d    = set_if.set_hh;
      mm_d    = set_if.set_mm;
      ss_d    = set_if.set_ss;
    end

    if (set_if.set_valid) begin
      err_d = ~set_ok;
    end
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      presc_q    <= '0;
      hh_q       <= '0;
      mm_q       <= '0;
      ss_q       <= '0;
      disp_cnt_q <= '0;
      disp_sel_q <= 1'b0;
      tick_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      hh_q       <= hh_d;
      mm_q       <= mm_d;
      ss_q       <= ss_d;
      disp_cnt_q <= disp_cnt_d;
      disp_sel_q <= disp_sel_d;
      tick_q     <= tick_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

`ifdef DIGITAL_CLOCK_ALARM_EN
  logic alarm_q, alarm_d;
  logic alarm_hit;

  // Only a genuine advance can fire; a set landing on the alarm time cannot.
  assign alarm_hit = wrap && !set_load && alarm_arm && (hh_d == alarm_hh) &&
                     (mm_d == alarm_mm) && (ss_d == 6'd0);

  always_comb begin
    alarm_d = alarm_q | alarm_hit;
    if (alarm_clr) begin
      alarm_d = 1'b0;
    end
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign alarm_out = alarm_q;
`endif

  assign tick_1hz       = tick_q;
  assign hours          = hh_q;
  assign minutes        = mm_q;
  assign seconds        = ss_q;
  assign disp_sel       = disp_sel_q;
  assign disp_hi        = disp_sel_q ? mm_q : {1'b0, hh_q};
  assign disp_lo        = disp_sel_q ? ss_q : mm_q;
  assign set_if.set_ack = ack_q;
  assign set_if.set_err = err_q;

endmodule
